// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave read path and its write-side sibling.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    LOAD,
    TX_BIT,
    M_ACK,
    WAIT_STOP
  } state_t;

  localparam logic [6:0] SLAVE_ADDR_DEF = 7'h42;
  localparam int         BUF_DEPTH      = 32;
  localparam logic       ACK            = 1'b0;
  localparam logic       NACK           = 1'b1;

  // Address byte addresses us and asks for a read (R/W bit set).
  function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] addr);
    return (addr_byte[7:1] == addr) && addr_byte[0];
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchronizer plus SCL edge and START/STOP detection for an I2C slave.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_lvl, scl_d, sda_d;

  // Idle bus is high, so flops reset high to avoid phantom edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync[0] <= scl_in;
      sda_sync[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_d <= scl_lvl;
      sda_d <= sda_level;
    end
  end

  assign scl_lvl   = scl_sync[SYNC_STAGES-1];
  assign sda_level = sda_sync[SYNC_STAGES-1];

  assign scl_rise  = scl_lvl & ~scl_d;
  assign scl_fall  = ~scl_lvl & scl_d;
  // SDA edges only count as bus conditions while SCL is steadily high.
  assign start_det = scl_lvl & scl_d & sda_d & ~sda_level;
  assign stop_det  = scl_lvl & scl_d & ~sda_d & sda_level;

endmodule

// File: rtl/i2c_slave_read_responder.sv
// I2C slave read path: ACKs its read address and shifts buffer bytes out on SDA.
module i2c_slave_read_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = SLAVE_ADDR_DEF,
  parameter int         ADDR_WIDTH  = 5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [ADDR_WIDTH-1:0] RADD,
  input  logic [7:0]            DOUT,
  output logic                  busy,
  output logic                  byte_sent
);

  logic   sda_lvl, scl_rise, scl_fall, start_det, stop_det;
  state_t state;
  logic [7:0] shreg;
  logic [2:0] bitcnt;
  logic       acked;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_level (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      RADD      <= '0;
      busy      <= 1'b0;
      byte_sent <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      acked     <= 1'b0;
    end else begin
      byte_sent <= 1'b0;
      // Bus conditions abort whatever is in flight; RADD is deliberately kept.
      if (stop_det || start_det) begin
        state  <= stop_det ? IDLE : ADDR;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        shreg  <= '0;
        bitcnt <= '0;
        acked  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shreg  <= {shreg[6:0], sda_lvl};
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7)
                state <= addr_hit({shreg[6:0], sda_lvl}, SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
            end
          end
          ADDR_ACK: begin
            // First fall ends the R/W bit and opens our ACK; the second closes it.
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= LOAD;
              end
            end
          end
          LOAD: begin
            shreg  <= DOUT;
            sda_oe <= ~DOUT[7];
            bitcnt <= 3'd7;
            state  <= TX_BIT;
          end
          TX_BIT: begin
            if (scl_fall) begin
              if (bitcnt == 3'd0) begin
                sda_oe <= 1'b0;
                acked  <= 1'b0;
                state  <= M_ACK;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
                bitcnt <= bitcnt - 3'd1;
              end
            end
          end
          M_ACK: begin
            if (scl_rise && !acked) begin
              byte_sent <= 1'b1;
              RADD      <= RADD + ADDR_WIDTH'(1);
              if (sda_lvl == ACK) begin
                acked <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end else if (scl_fall && acked) begin
              acked <= 1'b0;
              state <= LOAD;
            end
          end
          WAIT_STOP: sda_oe <= 1'b0;
          default:   state  <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_read_responder.sv
// Bench: bit-banged I2C master, RAM model and a byte scoreboard for the read responder.
module tb_i2c_slave_read_responder;

  localparam int Q = 6;  // clks per quarter SCL period

  typedef struct packed {
    logic [7:0] data;
    logic [4:0] radd_after;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe, busy, byte_sent;
  logic [4:0] radd;
  logic [7:0] dout = 8'h00;
  logic [7:0] mem [32];

  int   n_checks = 0, n_fail = 0;
  int   oe_cycles = 0, sent_cnt = 0, exp_sent = 0;
  int   model_radd = 0;
  logic [7:0] rx_byte = 8'h00;
  exp_t exp_q[$];

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;
  always @(posedge clk) dout <= mem[radd];

  i2c_slave_read_responder dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (m_scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .RADD      (radd),
    .DOUT      (dout),
    .busy      (busy),
    .byte_sent (byte_sent)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a finished byte.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sda_oe) oe_cycles++;
    if (byte_sent) begin
      sent_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte_sent: got byte %0h with empty queue", rx_byte);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", rx_byte, e.data);
        check("radd_after_byte", radd, e.radd_after);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    tick(Q); m_sda = b;
    tick(Q); m_scl = 1'b1;
    tick(Q); r = sda_bus;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic start_cond();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0;
  endtask

  task automatic stop_cond();
    tick(Q); m_sda = 1'b0;
    tick(Q); m_scl = 1'b1;
    tick(Q); m_sda = 1'b1;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ackb);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ackb);
  endtask

  task automatic read_byte(input logic mack);
    logic r;
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    rx_byte = d;
    clk_bit(mack, r);
  endtask

  // Full transaction; the model says only 0x42 with R/W=1 is answered.
  task automatic txn(input logic [6:0] a, input logic rw, input int nbytes, input logic do_start);
    logic ackb;
    logic hit;
    int   oe0;
    exp_t e;
    hit = (a == 7'h42) && rw;
    if (do_start) start_cond();
    oe0 = oe_cycles;
    send_byte({a, rw}, ackb);
    check("addr_ack", ackb, hit ? 0 : 1);
    if (hit) begin
      check("busy_after_ack", busy, 1);
      for (int k = 0; k < nbytes; k++) begin
        e.data       = mem[model_radd];
        model_radd   = (model_radd + 1) % 32;
        e.radd_after = 5'(model_radd);
        exp_q.push_back(e);
        exp_sent++;
        read_byte(k == nbytes - 1);
      end
      check("busy_after_nack", busy, 0);
    end else begin
      // A byte that would look like our read address must not be decoded now.
      send_byte({7'h42, 1'b1}, ackb);
      check("ignored_byte_ack", ackb, 1);
      check("no_drive_cycles", oe_cycles - oe0, 0);
    end
    stop_cond();
    check("radd_model", radd, model_radd);
    check("busy_after_stop", busy, 0);
  endtask

  initial begin
    logic r7, r6, r5;
    int   s0;
    for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
    tick(3);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_radd", radd, 0);
    check("reset_busy", busy, 0);
    check("reset_byte_sent", byte_sent, 0);
    reset = 1'b0;
    tick(4 * Q);

    // Basic four-byte read.
    s0 = sent_cnt;
    txn(7'h42, 1'b1, 4, 1'b1);
    check("t1_radd", radd, 4);
    check("t1_pulses", sent_cnt - s0, 4);

    // Wrong address, then our address as a write.
    txn(7'h43, 1'b1, 0, 1'b1);
    txn(7'h42, 1'b0, 0, 1'b1);

    // Walk up to 30, then read across the wrap.
    txn(7'h42, 1'b1, 26, 1'b1);
    check("t4_radd30", radd, 30);
    txn(7'h42, 1'b1, 3, 1'b1);
    check("t4_radd_wrap", radd, 1);

    // Randomized traffic on random buffer contents.
    for (int it = 0; it < 8; it++) begin
      logic [6:0] a;
      logic       rw;
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      a  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h42;
      rw = ($urandom_range(0, 3) != 0);
      txn(a, rw, $urandom_range(1, 5), 1'b1);
    end

    // Repeated START while data bit 4 (a released 1) is on the bus.
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom) | 8'h10;
    start_cond();
    send_byte({7'h42, 1'b1}, r7);
    check("rs_addr_ack", r7, 0);
    clk_bit(1'b1, r7);
    clk_bit(1'b1, r6);
    clk_bit(1'b1, r5);
    check("rs_partial_bits", {r7, r6, r5}, mem[model_radd][7:5]);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    check("rs_sda_released", sda_oe, 0);
    check("rs_busy_cleared", busy, 0);
    m_scl = 1'b0;
    txn(7'h42, 1'b1, 1, 1'b0);

    // Reset while the slave is holding its address ACK low.
    start_cond();
    for (int i = 7; i >= 0; i--) clk_bit(((8'h85 >> i) & 8'h01) != 0, r7);
    tick(Q);
    check("pre_reset_sda_oe", sda_oe, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_sda_oe", sda_oe, 0);
    check("async_reset_radd", radd, 0);
    check("async_reset_busy", busy, 0);
    tick(2);
    reset = 1'b0;
    model_radd = 0;
    m_sda = 1'b1;
    m_scl = 1'b1;
    tick(4 * Q);
    txn(7'h42, 1'b1, 1, 1'b1);

    tick(4 * Q);
    check("scoreboard_drained", exp_q.size(), 0);
    check("byte_sent_total", sent_cnt, exp_sent);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
